seq_det_scheduler: RTL and testbench

Time-multiplexed "101" pattern-detection engine shared by N_CH serial bit channels. A round-robin arbiter grants at most one channel per cycle. The granted channel's saved 2-bit Mealy context is stepped through the detector, and the context is written back. Detections are reported as a registered pulse tagged with the channel, and each channel keeps a saturating match counter. It sits between the per-channel serial receivers and the status/interrupt logic, replacing N dedicated sequence detectors.

---
 rtl/seq_det_pkg.sv | 18 +
 rtl/seq_det_step.sv | 26 ++
 rtl/seq_det_scheduler.sv | 105 ++++++++++
 tb/tb_seq_det_scheduler.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the time-multiplexed "101" detector.
// The context encoding lives here so the engine and the scheduler agree on it.
package seq_det_pkg;

   localparam int unsigned STATE_W = 2;

   typedef logic [STATE_W-1:0] state_t;

   localparam state_t S0 = 2'b00;
   localparam state_t S1 = 2'b01;
   localparam state_t S2 = 2'b10;

   // At least one bit, so a single-channel build still has a legal index port.
   function automatic int unsigned calc_ch_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/seq_det_step.sv
// Combinational Mealy step of the overlapping "101" detector.
// One instance is shared by all channels through the scheduler.
module seq_det_step
   import seq_det_pkg::*;
(
   input  state_t state,
   input  logic   din,
   output state_t next_state,
   output logic   detect
);

   always_comb begin
      next_state = S0;
      detect     = 1'b0;
      case (state)
         S0: next_state = din ? S1 : S0;
         S1: next_state = din ? S1 : S2;
         S2: begin
            next_state = din ? S1 : S0;
            detect     = din;
         end
         default: next_state = S0;
      endcase
   end

endmodule

// File: rtl/seq_det_scheduler.sv
// Round-robin scheduler sharing one "101" detector across N_CH serial channels,
// with per-channel saved contexts, saturating match counters and a tagged pulse.
module seq_det_scheduler
   import seq_det_pkg::*;
#(
   parameter  int unsigned N_CH  = 4,
   parameter  int unsigned CNT_W = 8,
   localparam int unsigned CH_W  = calc_ch_w(N_CH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_CH-1:0]         ch_enable,
   input  logic [N_CH-1:0]         ch_valid,
   input  logic [N_CH-1:0]         ch_bit,
   output logic [N_CH-1:0]         ch_ready,
   input  logic                    clr_counts,
   output logic                    det_valid,
   output logic [CH_W-1:0]         det_ch,
   output logic [N_CH*CNT_W-1:0]   match_cnt
);

   state_t           ctx_q [N_CH];
   logic [CNT_W-1:0] cnt_q [N_CH];
   logic [CH_W-1:0]  ptr_q;

   logic [N_CH-1:0]  req;
   logic [N_CH-1:0]  grant;
   logic [CH_W-1:0]  grant_idx;
   logic             grant_any;
   logic [CH_W-1:0]  ptr_next;
   int unsigned      idx;

   state_t           step_state;
   state_t           step_next;
   logic             step_detect;

   // Search from ptr upward with wrap; nothing is granted while in reset.
   always_comb begin
      req       = ch_valid & ch_enable;
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      idx       = 0;
      if (rst) begin
         for (int unsigned i = 0; i < N_CH; i++) begin
            idx = (32'(ptr_q) + i) % N_CH;
            if (!grant_any && req[idx]) begin
               grant_any  = 1'b1;
               grant[idx] = 1'b1;
               grant_idx  = CH_W'(idx);
            end
         end
      end
   end

   assign ch_ready   = grant;
   assign ptr_next   = (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + CH_W'(1);
   assign step_state = ctx_q[grant_idx];

   seq_det_step u_step (
      .state      (step_state),
      .din        (ch_bit[grant_idx]),
      .next_state (step_next),
      .detect     (step_detect)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned c = 0; c < N_CH; c++) begin
            ctx_q[c] <= S0;
            cnt_q[c] <= '0;
         end
         ptr_q     <= '0;
         det_valid <= 1'b0;
         det_ch    <= '0;
      end else begin
         for (int unsigned c = 0; c < N_CH; c++) begin
            // A disabled channel drops any partial sequence.
            if (!ch_enable[c]) begin
               ctx_q[c] <= S0;
            end else if (grant[c]) begin
               ctx_q[c] <= step_next;
            end
            if (clr_counts) begin
               cnt_q[c] <= '0;
            end else if (grant[c] && step_detect && (cnt_q[c] != '1)) begin
               cnt_q[c] <= cnt_q[c] + CNT_W'(1);
            end
         end
         det_valid <= grant_any & step_detect;
         if (grant_any) begin
            det_ch <= grant_idx;
            ptr_q  <= ptr_next;
         end
      end
   end

   always_comb begin
      match_cnt = '0;
      for (int unsigned c = 0; c < N_CH; c++) begin
         match_cnt[c*CNT_W +: CNT_W] = cnt_q[c];
      end
   end

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Directed bench for seq_det_scheduler: a bit-history reference model feeds a
// scoreboard of expected outputs, plus explicit checks of the key scenarios.
module tb_seq_det_scheduler;
   import seq_det_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] ch_enable = '0;
   logic [3:0] ch_valid = '0;
   logic [3:0] ch_bit = '0;
   logic       clr_counts = 1'b0;
   logic [3:0] ch_ready;
   logic       det_valid;
   logic [1:0] det_ch;
   logic [7:0] match_cnt;

   seq_det_scheduler #(
      .N_CH  (4),
      .CNT_W (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ch_enable  (ch_enable),
      .ch_valid   (ch_valid),
      .ch_bit     (ch_bit),
      .ch_ready   (ch_ready),
      .clr_counts (clr_counts),
      .det_valid  (det_valid),
      .det_ch     (det_ch),
      .match_cnt  (match_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       dv;
      logic [1:0] dc;
      logic [7:0] cnt;
   } exp_t;

   exp_t       exp_q[$];
   int         checks = 0;
   int         errors = 0;
   int         det_seen = 0;
   logic [3:0] obs_rdy;
   logic       obs_dv;
   logic [7:0] obs_cnt;

   // Reference model: last two consumed bits per channel, not an FSM encoding.
   int         m_ptr = 0;
   logic [1:0] m_hist[4];
   int         m_n[4];
   int         m_cnt[4];
   int         m_det_ch = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick(input string tag);
      logic [3:0] exp_rdy;
      int         g;
      logic       det;
      exp_t       e;
      exp_t       got;
      #1;
      exp_rdy = '0;
      g = -1;
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            int c;
            c = (m_ptr + i) % 4;
            if (g < 0 && ch_valid[c] && ch_enable[c]) g = c;
         end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      obs_rdy = ch_ready;
      check({tag, "_ready"}, 32'(obs_rdy), 32'(exp_rdy));

      det = 1'b0;
      if (g >= 0) det = (m_n[g] >= 2) && (m_hist[g] == 2'b10) && ch_bit[g];
      if (!rst) begin
         for (int c = 0; c < 4; c++) begin
            m_hist[c] = '0;
            m_n[c] = 0;
            m_cnt[c] = 0;
         end
         m_ptr = 0;
         m_det_ch = 0;
      end else begin
         for (int c = 0; c < 4; c++) begin
            if (!ch_enable[c]) begin
               m_hist[c] = '0;
               m_n[c] = 0;
            end
         end
         if (g >= 0) begin
            m_hist[g] = {m_hist[g][0], ch_bit[g]};
            if (m_n[g] < 2) m_n[g]++;
            m_ptr = (g + 1) % 4;
            m_det_ch = g;
            if (det && m_cnt[g] < 3) m_cnt[g]++;
         end
         if (clr_counts) for (int c = 0; c < 4; c++) m_cnt[c] = 0;
      end
      e.dv = det;
      e.dc = 2'(m_det_ch);
      e.cnt = {2'(m_cnt[3]), 2'(m_cnt[2]), 2'(m_cnt[1]), 2'(m_cnt[0])};
      exp_q.push_back(e);

      @(posedge clk);
      #1;
      got = exp_q.pop_front();
      obs_dv = det_valid;
      obs_cnt = match_cnt;
      if (obs_dv === 1'b1) det_seen++;
      check({tag, "_det_valid"}, 32'(obs_dv), 32'(got.dv));
      check({tag, "_det_ch"}, 32'(det_ch), 32'(got.dc));
      check({tag, "_match_cnt"}, 32'(obs_cnt), 32'(got.cnt));
      @(negedge clk);
   endtask

   initial begin
      // 1: reset with all channels requesting, then first grant to ch0
      rst = 1'b0;
      ch_valid = 4'hF;
      ch_enable = 4'hF;
      for (int i = 0; i < 3; i++) begin
         tick("t1_rst");
         check("t1_rst_ready0", 32'(obs_rdy), 32'h0);
         check("t1_rst_cnt0", 32'(obs_cnt), 32'h0);
      end
      rst = 1'b1;
      tick("t1_rel");
      check("t1_first_grant", 32'(obs_rdy), 32'h1);

      // 2: single channel 1,0,1,0,1 on ch1
      ch_valid = '0;
      clr_counts = 1'b1;
      tick("t2_clr");
      clr_counts = 1'b0;
      ch_enable = 4'b0010;
      ch_valid = 4'b0010;
      det_seen = 0;
      for (int i = 0; i < 5; i++) begin
         ch_bit = {2'b00, ~i[0], 1'b0};
         tick("t2_bit");
         if (i == 2 || i == 4) check("t2_detect", {31'(det_ch), obs_dv}, 32'b11);
      end
      check("t2_det_count", 32'(det_seen), 32'd2);
      check("t2_cnt1", 32'(obs_cnt[3:2]), 32'd2);

      // 3: interleave, from a fresh reset so ptr starts at ch0
      rst = 1'b0;
      ch_valid = '0;
      tick("t3_rst");
      rst = 1'b1;
      ch_enable = 4'hF;
      ch_valid = 4'hF;
      det_seen = 0;
      for (int i = 1; i <= 12; i++) begin
         int r;
         logic [2:0] b0;
         logic [2:0] b2;
         b0 = 3'b101;
         b2 = 3'b011;
         r = (i - 1) / 4;
         ch_bit = '0;
         if (r < 3) begin
            ch_bit[0] = b0[r];
            ch_bit[2] = b2[r];
         end
         tick("t3_step");
         check("t3_rotate", 32'(obs_rdy), 32'(4'b0001 << ((i - 1) % 4)));
         if (i == 9) check("t3_detect_ch0", {31'(det_ch), obs_dv}, 32'b01);
      end
      check("t3_det_count", 32'(det_seen), 32'd1);

      // 4: sparse requests on ch0 and ch3
      ch_valid = 4'b1001;
      ch_bit = '0;
      for (int i = 0; i < 4; i++) begin
         tick("t4_step");
         check("t4_alternate", 32'(obs_rdy), (i % 2 == 0) ? 32'h1 : 32'h8);
      end

      // 5: disable mid-pattern on ch2
      ch_valid = '0;
      ch_enable = 4'b1011;
      tick("t5_flush");
      det_seen = 0;
      ch_enable = 4'hF;
      ch_valid = 4'b0100;
      ch_bit = 4'b0100;
      tick("t5_b1");
      ch_bit = 4'b0000;
      tick("t5_b0");
      ch_enable = 4'b1011;
      tick("t5_off");
      ch_enable = 4'hF;
      ch_bit = 4'b0100;
      tick("t5_b1b");
      check("t5_ctx_s1", 32'(dut.ctx_q[2]), 32'(S1));
      check("t5_no_detect", 32'(det_seen), 32'd0);

      // 6: saturation at 3, then clear colliding with a detect
      ch_valid = '0;
      clr_counts = 1'b1;
      tick("t6_clr");
      clr_counts = 1'b0;
      ch_valid = 4'b0001;
      det_seen = 0;
      for (int i = 0; i < 9; i++) begin
         ch_bit = {3'b000, ~i[0]};
         tick("t6_bit");
      end
      check("t6_det_count", 32'(det_seen), 32'd4);
      check("t6_saturated", 32'(obs_cnt[1:0]), 32'd3);
      ch_bit = 4'b0000;
      tick("t6_b0");
      ch_bit = 4'b0001;
      clr_counts = 1'b1;
      tick("t6_clr_det");
      clr_counts = 1'b0;
      check("t6_clr_det_valid", 32'(obs_dv), 32'd1);
      check("t6_clr_wins", 32'(obs_cnt[1:0]), 32'd0);

      ch_valid = '0;
      tick("t_end");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
